// File: rtl/pad_bus_responder.sv
// pad_bus_responder: external-device end of the bidirectional pad data bus.
// Optional parity checking is enabled by defining PAD_BUS_RESPONDER_PARITY_EN.
module pad_bus_responder #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                  MasterClock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      padO,
  input  logic [WIDTH-1:0]      padE,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  nRD,
  input  logic                  nWR,
  input  logic                  clearError,
`ifdef PAD_BUS_RESPONDER_PARITY_EN
  input  logic                  parityIn,
  output logic                  parityOut,
`endif
  output logic [WIDTH-1:0]      extData,
  output logic                  extDriveEn,
  output logic                  ready,
  output logic                  busError,
  output logic [2:0]            state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_RDRV  = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0]            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_first;
  logic [WIDTH-1:0]      r_data;
  logic                  r_drive;
  logic                  r_ready;
  logic                  r_err;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic w_par_ok;
  logic w_wr_ok;
  logic w_err_set;

`ifdef PAD_BUS_RESPONDER_PARITY_EN
  logic r_par;
  assign w_par_ok  = (parityIn == ^padO);
  assign parityOut = r_par;
`else
  assign w_par_ok = 1'b1;
`endif

  // A write is only accepted when every pad is driven (and parity agrees).
  assign w_wr_ok = (&padE) && w_par_ok;

  // Collect every protocol/contention error source of this cycle.
  always_comb begin
    w_err_set = 1'b0;
    if (r_state == S_IDLE && !nRD && !nWR)
      w_err_set = 1'b1;
    if (r_state == S_WRITE && !w_wr_ok)
      w_err_set = 1'b1;
    if (r_state == S_RDRV && !nRD && !r_first &&
        r_drive && (|padE))
      w_err_set = 1'b1;
  end

  // Main transaction FSM, register file and registered bus outputs.
  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_first <= 1'b0;
      r_data  <= '0;
      r_drive <= 1'b0;
      r_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
`ifdef PAD_BUS_RESPONDER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_drive <= 1'b0;
          if (!nWR && nRD) begin
            r_addr  <= addr;
            r_state <= S_WRITE;
          end else if (!nRD && nWR) begin
            r_addr <= addr;
            r_cnt  <= WS;
            if (WS == 4'd0) begin
              r_state <= S_RDRV;
              r_first <= 1'b1;
            end else begin
              r_state <= S_RWAIT;
            end
          end else if (!nRD && !nWR) begin
            r_state <= S_HOLD;
          end
        end
        S_WRITE: begin
          if (w_wr_ok) begin
            r_mem[r_addr] <= padO;
            r_ready       <= 1'b1;
          end
          r_state <= S_HOLD;
        end
        S_RWAIT: begin
          if (nRD) begin
            r_state <= S_TURN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_RDRV;
              r_first <= 1'b1;
            end
          end
        end
        S_RDRV: begin
          if (nRD) begin
            r_state <= S_TURN;
            r_first <= 1'b0;
            r_drive <= 1'b0;
            r_ready <= 1'b0;
          end else if (r_first) begin
            r_first <= 1'b0;
            r_data  <= r_mem[r_addr];
            r_drive <= 1'b1;
            r_ready <= 1'b1;
`ifdef PAD_BUS_RESPONDER_PARITY_EN
            r_par   <= ^r_mem[r_addr];
`endif
          end else if (r_drive && (|padE)) begin
            r_drive <= 1'b0;
          end
        end
        S_TURN: begin
          r_drive <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        S_HOLD: begin
          r_ready <= 1'b0;
          if (nRD && nWR)
            r_state <= S_IDLE;
        end
        default: begin
          r_drive <= 1'b0;
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a new error wins over a same-cycle clear.
  always_ff @(posedge MasterClock or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
    else if (clearError)
      r_err <= 1'b0;
  end

  assign extData    = r_data;
  assign extDriveEn = r_drive;
  assign ready      = r_ready;
  assign busError   = r_err;
  assign state      = r_state;

endmodule

// File: doc/pad_bus_responder.md
Name: pad_bus_responder

Overview:
- External-device end of the bidirectional pad-cell data bus: the model of the memory/peripheral that sits on the far side of the pads.
- Accepts core writes: samples the pad output value while the core's per-bit enables are all high.
- Services core reads: drives data back onto the pad input after programmable wait states, while the core enables are all low.
- Keeps a small register file, flags bus contention and protocol errors, and enforces a one-cycle turnaround before releasing the bus.

Parameters:
- WIDTH, 8, data bus width in bits (one pad cell per bit).
- ADDR_WIDTH, 4, register-file address width; depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 2, cycles between read acceptance and data drive; legal range 0..15.

Ports:
- MasterClock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- padO  input  WIDTH  per-bit value the core presents at the pads.
- padE  input  WIDTH  per-bit core drive enable (1 = core driving that bit).
- addr  input  ADDR_WIDTH  register address from the core.
- nRD  input  1  active-low read strobe.
- nWR  input  1  active-low write strobe.
- clearError  input  1  synchronous clear of busError.
- extData  output  WIDTH  value driven toward the pad input when extDriveEn=1.
- extDriveEn  output  1  responder drives extData.
- ready  output  1  transaction acknowledge.
- busError  output  1  sticky error flag.
- state  output  3  encoded FSM state, for debug.

Behaviour:
- Reset (asynchronous) forces:
  - outputs: extData=0, extDriveEn=0, ready=0, busError=0, state=IDLE;
  - every register-file word to 0, the wait counter to 0, the latched address to 0.
- Reset takes effect mid-transaction with no completion of the write or read in progress.
- All outputs are registered. Strobes and padE are sampled at rising edges.
- States and encodings: IDLE=0, WRITE=1, READ_WAIT=2, READ_DRIVE=3, TURNAROUND=4, HOLD=5.
- IDLE:
  - nWR=0 and nRD=1: latch addr, go to WRITE.
  - nRD=0 and nWR=1: latch addr, load counter with WAIT_STATES, go to READ_WAIT (READ_DRIVE directly if WAIT_STATES=0).
  - nRD=0 and nWR=0: set busError, go to HOLD.
- WRITE (one cycle):
  - padE all ones: mem[latched addr] <= padO, ready=1 for exactly one cycle.
  - padE not all ones: write discarded, busError set, ready stays 0.
  - Then go to HOLD.
- READ_WAIT: counter decrements each cycle. Leaving READ_WAIT takes exactly WAIT_STATES cycles; on the last of those cycles go to READ_DRIVE.
- READ_DRIVE:
  - Entry cycle: extData <= mem[latched addr], extDriveEn=1, ready=1.
  - ready is held while nRD=0.
  - Any padE bit =1 while driving: set busError; extDriveEn falls on the next edge and stays 0 for the rest of the transaction.
  - nRD=1: go to TURNAROUND.
- TURNAROUND (one cycle): extDriveEn=0, ready=0; extData holds its value. Then go to IDLE.
- HOLD: ready=0; wait until nRD=1 and nWR=1, then go to IDLE.
- Strobe released early:
  - nRD=1 during READ_WAIT aborts: go to TURNAROUND, no drive, no ready, no error.
  - nWR=1 on the WRITE cycle itself does not abort; the capture still occurs.
- busError: set takes priority over clearError in the same cycle. clearError has no other effect.
- Write-then-read to the same address returns the newly written data; no bypass hazard, since the write completes before IDLE.
- Latency from the nRD low edge to extDriveEn=1 is WAIT_STATES+2 cycles.

Optional Feature:
- Macro: PAD_BUS_RESPONDER_PARITY_EN.
- When defined:
  - Adds input parityIn (1) and output parityOut (1).
  - On the WRITE capture, if parityIn differs from the XOR of padO: write discarded, busError set.
  - parityOut is the registered XOR of extData, updated whenever extData updates, reset 0.
- When undefined: neither port exists and there is no parity checking; behaviour is otherwise identical.

Test Plan:
- Write 0xA5 to addr 3 with padE=0xFF, then read addr 3 (WAIT_STATES=2): ready pulses 1 cycle on the write; on the read, extDriveEn=1, extData=0xA5 and ready=1 four cycles after nRD falls.
- Write with padE=0xFE: busError=1, and a later read of that address returns 0x00.
- During READ_DRIVE, set padE=0x01: busError=1 and extDriveEn drops the next cycle. Release nRD: TURNAROUND, then IDLE.
- nRD and nWR low together: busError=1, state=HOLD until both are high. Then pulse clearError: busError returns to 0.
- Assert reset mid-READ_WAIT: all outputs 0 immediately and asynchronously, state=IDLE; a subsequent read of any address returns 0x00.
- With PAD_BUS_RESPONDER_PARITY_EN: write 0x03 with parityIn=1 → rejected, busError=1. Write 0x07 with parityIn=1 → accepted; reading it back gives parityOut=1.
